// File: rtl/tdc_if_pkg.sv
// Shared widths, entry type and read-FSM states for the TDC result-FIFO read interface.
package tdc_if_pkg;
  localparam int TDC_DATA_W = 28;
  localparam int TDC_ADDR_W = 4;

  typedef struct packed {
    logic [TDC_ADDR_W-1:0] addr;
    logic [TDC_DATA_W-1:0] data;
  } tdc_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tdc_rd_state_t;
endpackage

// File: rtl/tdc_resp_fifo.sv
// Synchronous FIFO of tdc_entry_t; a push while full is accepted only if a pop frees the slot.
module tdc_resp_fifo
  import tdc_if_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  tdc_entry_t                 i_wr_entry,
  input  logic                       i_pop,
  output tdc_entry_t                 o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  tdc_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tdc_fifo_responder.sv
// Device-side TDC result-FIFO responder (EF1/CSN/RDN read port).
// Optional load flag output LF is built when TDC_RESP_LOAD_FLAG_EN is defined.
module tdc_fifo_responder
  import tdc_if_pkg::*;
#(
  parameter int DATA_W   = TDC_DATA_W,
  parameter int ADDR_W   = TDC_ADDR_W,
  parameter int DEPTH    = 16,
  parameter int EF_DELAY = 4
`ifdef TDC_RESP_LOAD_FLAG_EN
  , parameter int LF_THRESH = 12
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              CSN,
  input  logic              RDN,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              EF1,
  output logic              ovf,
  output logic              udf
`ifdef TDC_RESP_LOAD_FLAG_EN
  , output logic            LF
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(EF_DELAY + 1);

  tdc_rd_state_t    r_state;
  tdc_rd_state_t    w_state_nxt;
  logic             r_rdn_q;
  logic             w_rd_start;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_fill;
  logic             w_drain;
  logic             w_empty_nxt;
  logic [CNT_W-1:0] w_count;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  tdc_entry_t       w_head;
  tdc_entry_t       w_wr_entry;

  assign w_wr_entry = {wr_addr, wr_data};

  tdc_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (wr_en),
    .i_wr_entry (w_wr_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // RDN history keeps tracking through reset so a strobe held low across reset is not seen as a new edge.
  always_ff @(posedge clk) begin
    r_rdn_q <= RDN;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!RDN && r_rdn_q && !CSN) begin
          w_rd_start  = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (RDN) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop       = w_rd_start && !EF1;
  assign w_fill      = w_empty && wr_en;
  assign w_drain     = w_pop && !wr_en && (w_count == CNT_W'(1));
  assign w_empty_nxt = w_drain || (w_empty && !wr_en);

  // Timer counts down the EF1 hold-off after the first entry lands in an empty FIFO.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_empty_nxt)          w_timer_nxt = '0;
    else if (w_fill)          w_timer_nxt = TMR_W'(EF_DELAY - 1);
    else if (r_timer != '0)   w_timer_nxt = r_timer - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      EF1      <= 1'b1;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      data_out <= '0;
      addr_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      EF1     <= w_empty_nxt || (w_timer_nxt != '0);
      if (wr_en && w_full && !w_pop) ovf <= 1'b1;
      if (w_rd_start) begin
        if (!EF1) begin
          data_out <= w_head.data;
          addr_out <= w_head.addr;
        end else begin
          data_out <= '0;
          addr_out <= '0;
          udf      <= 1'b1;
        end
      end
    end
  end

`ifdef TDC_RESP_LOAD_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) LF <= 1'b0;
    else       LF <= (32'(w_count) >= LF_THRESH);
  end
`endif
endmodule

// File: tb/tb_tdc_fifo_responder.sv
// Bench for tdc_fifo_responder: directed vector table, hand sequences, and randomized run against a queue model.
module tb_tdc_fifo_responder;
  localparam int DEPTH    = 16;
  localparam int EF_DELAY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        CSN;
  logic        RDN;
  logic [27:0] data_out;
  logic [3:0]  addr_out;
  logic        EF1;
  logic        ovf;
  logic        udf;
`ifdef TDC_RESP_LOAD_FLAG_EN
  logic        LF;
`endif

  always #5 clk = ~clk;

  tdc_fifo_responder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .CSN      (CSN),
    .RDN      (RDN),
    .data_out (data_out),
    .addr_out (addr_out),
    .EF1      (EF1),
    .ovf      (ovf),
    .udf      (udf)
`ifdef TDC_RESP_LOAD_FLAG_EN
    , .LF     (LF)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a queue of {addr,data} plus the cycle at which EF1 may fall.
  logic [31:0] mq[$];
  int          m_cyc   = 0;
  int          m_avail = 0;
  bit          m_active = 1'b0;
  bit          m_rdn_prev = 1'b1;
  logic [27:0] m_data = '0;
  logic [3:0]  m_addr = '0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;

  function automatic bit model_ef1();
    return (mq.size() == 0) || (m_cyc < m_avail);
  endfunction

  task automatic model_step(input bit rst, input bit we, input logic [3:0] a,
                            input logic [27:0] d, input bit csn, input bit rdn);
    bit          was_empty;
    bit          ef;
    bit          start;
    logic [31:0] e;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_avail  = 0;
      m_data   = '0;
      m_addr   = '0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      ef        = model_ef1();
      start     = !m_active && !rdn && m_rdn_prev && !csn;
      if (start) m_active = 1'b1;
      else if (m_active && rdn) m_active = 1'b0;
      if (start) begin
        if (!ef) begin
          e = mq.pop_front();
          m_addr = e[31:28];
          m_data = e[27:0];
        end else begin
          m_addr = '0;
          m_data = '0;
          m_udf  = 1'b1;
        end
      end
      if (we) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({a, d});
          if (was_empty) m_avail = m_cyc + EF_DELAY;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_rdn_prev = rdn;
    m_cyc++;
  endtask

  task automatic drive(input bit rst, input bit we, input logic [3:0] a,
                       input logic [27:0] d, input bit csn, input bit rdn);
    reset   = rst;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    CSN     = csn;
    RDN     = rdn;
    model_step(rst, we, a, d, csn, rdn);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input int i);
    chk($sformatf("rnd%0d.data", i), 32'(data_out), 32'(m_data));
    chk($sformatf("rnd%0d.addr", i), 32'(addr_out), 32'(m_addr));
    chk($sformatf("rnd%0d.ef1", i), 32'(EF1), 32'(model_ef1()));
    chk($sformatf("rnd%0d.ovf", i), 32'(ovf), 32'(m_ovf));
    chk($sformatf("rnd%0d.udf", i), 32'(udf), 32'(m_udf));
  endtask

  typedef struct {
    bit          rst;
    bit          we;
    logic [3:0]  a;
    logic [27:0] d;
    bit          csn;
    bit          rdn;
    bit          e_ef1;
    logic [27:0] e_data;
    logic [3:0]  e_addr;
    bit          e_udf;
    bit          e_ovf;
  } vec_t;

  function automatic vec_t mk(input int rst, input int we, input int a, input int d,
                              input int csn, input int rdn, input int ef1, input int ed,
                              input int ea, input int eu, input int eo);
    vec_t v;
    v.rst = rst[0]; v.we = we[0]; v.a = a[3:0]; v.d = d[27:0];
    v.csn = csn[0]; v.rdn = rdn[0]; v.e_ef1 = ef1[0]; v.e_data = ed[27:0];
    v.e_addr = ea[3:0]; v.e_udf = eu[0]; v.e_ovf = eo[0];
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    bit          we;
    bit          csn;
    bit          rdn;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; CSN = 1'b1; RDN = 1'b1;

    // rst we a d csn rdn | ef1 data addr udf ovf (values in the following cycle)
    tbl[0]  = mk(1, 0, 0, 0,    1, 1, 1, 0,    0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 1234, 1, 1, 1, 0,    0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,    1, 1, 1, 0,    0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,    1, 1, 1, 0,    0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,    1, 1, 0, 0,    0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,    0, 0, 1, 1234, 5, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,    0, 0, 1, 1234, 5, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,    1, 1, 1, 1234, 5, 0, 0);
    tbl[8]  = mk(0, 1, 3, 85,   1, 1, 1, 1234, 5, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,    1, 1, 1, 1234, 5, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,    1, 1, 1, 1234, 5, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,    1, 1, 0, 1234, 5, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,    1, 0, 0, 1234, 5, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,    1, 0, 0, 1234, 5, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,    1, 1, 0, 1234, 5, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,    0, 0, 1, 85,   3, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,    0, 1, 1, 85,   3, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,    0, 0, 1, 0,    0, 1, 0);
    tbl[18] = mk(0, 0, 0, 0,    1, 1, 1, 0,    0, 1, 0);
    tbl[19] = mk(0, 1, 7, 99,   1, 1, 1, 0,    0, 1, 0);
    tbl[20] = mk(0, 0, 0, 0,    1, 1, 1, 0,    0, 1, 0);
    tbl[21] = mk(0, 0, 0, 0,    0, 0, 1, 0,    0, 1, 0);
    tbl[22] = mk(0, 0, 0, 0,    0, 1, 0, 0,    0, 1, 0);
    tbl[23] = mk(0, 0, 0, 0,    1, 1, 0, 0,    0, 1, 0);
    tbl[24] = mk(0, 0, 0, 0,    0, 0, 1, 99,   7, 1, 0);
    tbl[25] = mk(0, 0, 0, 0,    1, 1, 1, 99,   7, 1, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].csn, tbl[i].rdn);
      chk($sformatf("vec%0d.ef1", i),  32'(EF1),      32'(tbl[i].e_ef1));
      chk($sformatf("vec%0d.data", i), 32'(data_out), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d.addr", i), 32'(addr_out), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.udf", i),  32'(udf),      32'(tbl[i].e_udf));
      chk($sformatf("vec%0d.ovf", i),  32'(ovf),      32'(tbl[i].e_ovf));
    end

    // Overflow on the 17th push, then 16 ordered reads.
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 4'(i), 28'(i), 1'b1, 1'b1);
      if (i == 15) chk("fill16.ovf", 32'(ovf), 32'd0);
    end
    chk("fill17.ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
      chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d.addr", i), 32'(addr_out), 32'(i[3:0]));
      drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    end
    chk("drain.ef1", 32'(EF1), 32'd1);
    chk("drain.udf", 32'(udf), 32'd0);

    // Simultaneous push and pop at occupancy 1.
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4'd1, 28'd11, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    chk("sim.ready", 32'(EF1), 32'd0);
    drive(1'b0, 1'b1, 4'd2, 28'd77, 1'b0, 1'b0);
    chk("sim.data", 32'(data_out), 32'd11);
    chk("sim.ef1a", 32'(EF1), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    chk("sim.ef1b", 32'(EF1), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 0);
    chk("sim.data77", 32'(data_out), 32'd77);
    chk("sim.addr2", 32'(addr_out), 32'd2);
    chk("sim.ef1c", 32'(EF1), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);

`ifdef TDC_RESP_LOAD_FLAG_EN
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 4'd0, 28'(i), 1'b1, 1'b1);
    chk("lf.before", 32'(LF), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    chk("lf.set", 32'(LF), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    chk("lf.clear", 32'(LF), 32'd0);
`endif

    // Reset while RDN is held low mid-read.
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'd9, 28'(100 + i), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    chk("rst6.ready", 32'(EF1), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    chk("rst6.data", 32'(data_out), 32'd100);
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    chk("rst6.ef1", 32'(EF1), 32'd1);
    chk("rst6.data0", 32'(data_out), 32'd0);
    chk("rst6.addr0", 32'(addr_out), 32'd0);
    chk("rst6.udf0", 32'(udf), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    chk("rst6.hold.udf", 32'(udf), 32'd0);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b1);
    chk("rst6.rise.udf", 32'(udf), 32'd0);
    chk("rst6.rise.ef1", 32'(EF1), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b0, 1'b0);
    chk("rst6.read.udf", 32'(udf), 32'd1);
    chk("rst6.read.data", 32'(data_out), 32'd0);
    chk("rst6.read.ef1", 32'(EF1), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);

    // Randomized traffic against the queue model, alternating light and heavy push phases.
    drive(1'b1, 1'b0, 4'd0, 28'd0, 1'b1, 1'b1);
    rdn = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      we  = ($urandom_range(0, 99) < (((i / 250) % 2) == 1 ? 85 : 25));
      csn = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) rdn = ~rdn;
      drive(1'b0, we, 4'($urandom_range(0, 15)), 28'($urandom), csn, rdn);
      chk_model(i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
